// File: rtl/tone_period_counter.sv
// Programmable free-running tone counter: count word, square-wave tone and wrap strobe.
// Half-period changes are staged in a pending register and applied only at a wrap or from IDLE.
module tone_period_counter #(
    parameter int unsigned CNT_W        = 19,
    parameter int unsigned DEFAULT_HALF = 500000,
    parameter int unsigned MIN_HALF     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] half_period,
    input  logic             load,
    output logic [CNT_W-1:0] count,
    output logic             tone_out,
    output logic             wrap,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] active_q;
    logic [CNT_W-1:0] pending_q;
    logic             pend_valid_q;
    logic             tone_q;
    logic             wrap_q;
    logic             busy_q;

    logic [CNT_W-1:0] pending_d;
    logic             at_top;

    // Requests below the minimum are clamped so the count always has two phases.
    assign pending_d = (half_period < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : half_period;
    assign at_top    = (count_q >= (active_q - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            active_q     <= CNT_W'(DEFAULT_HALF);
            pending_q    <= CNT_W'(DEFAULT_HALF);
            pend_valid_q <= 1'b0;
            tone_q       <= 1'b0;
            wrap_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            if (load) begin
                pending_q    <= pending_d;
                pend_valid_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    tone_q  <= 1'b0;
                    wrap_q  <= 1'b0;
                    if (pend_valid_q) begin
                        active_q     <= pending_q;
                        pend_valid_q <= load;
                    end
                    state_q <= enable ? RUN : IDLE;
                    busy_q  <= enable;
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                        tone_q  <= 1'b0;
                        wrap_q  <= 1'b0;
                    end else if (at_top) begin
                        count_q <= '0;
                        tone_q  <= ~tone_q;
                        wrap_q  <= 1'b1;
                        // A load landing on the wrap cycle is applied immediately.
                        if (load) begin
                            active_q     <= pending_d;
                            pend_valid_q <= 1'b0;
                        end else if (pend_valid_q) begin
                            active_q     <= pending_q;
                            pend_valid_q <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                        wrap_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count    = count_q;
    assign tone_out = tone_q;
    assign wrap     = wrap_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tone_period_counter.sv
// Bench for tone_period_counter: directed scenarios then random traffic, each cycle
// compared against a cycle-level arithmetic reference model.
module tb_tone_period_counter;

    localparam int unsigned CNT_W    = 19;
    localparam int          DEF_HALF = 500000;
    localparam int          MIN_HALF = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             load;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] count;
    logic             tone_out;
    logic             wrap;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_run;
    int m_cnt;
    int m_act;
    int m_pend;
    bit m_pv;
    bit m_tone;
    bit m_wrap;

    tone_period_counter #(
        .CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF), .MIN_HALF(MIN_HALF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .half_period(half_period),
        .load(load), .count(count), .tone_out(tone_out), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge of the specified behaviour, in plain arithmetic.
    task automatic model_tick(input bit r, input bit en, input bit ld, input int hp);
        int req;
        req = (hp < MIN_HALF) ? MIN_HALF : hp;
        if (r) begin
            m_run = 0; m_cnt = 0; m_tone = 0; m_wrap = 0;
            m_act = DEF_HALF; m_pend = DEF_HALF; m_pv = 0;
        end else if (!m_run) begin
            m_cnt = 0; m_tone = 0; m_wrap = 0;
            if (m_pv) begin m_act = m_pend; m_pv = 0; end
            if (ld) begin m_pend = req; m_pv = 1; end
            m_run = en;
        end else if (!en) begin
            m_run = 0; m_cnt = 0; m_tone = 0; m_wrap = 0;
            if (ld) begin m_pend = req; m_pv = 1; end
        end else if (m_cnt + 1 == m_act) begin
            m_cnt = 0; m_tone = !m_tone; m_wrap = 1;
            if (ld) begin m_pend = req; m_act = req; end
            else if (m_pv) m_act = m_pend;
            m_pv = 0;
        end else begin
            m_cnt = m_cnt + 1; m_wrap = 0;
            if (ld) begin m_pend = req; m_pv = 1; end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit ld, input int hp);
        reset = r; enable = en; load = ld; half_period = CNT_W'(hp);
        @(posedge clk);
        model_tick(r, en, ld, hp);
        #1;
        check("count", 32'(count), 32'(m_cnt));
        check("tone_out", 32'(tone_out), 32'(m_tone));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("busy", 32'(busy), 32'(m_run));
    endtask

    // Advance with enable held until the model count reaches target (bounded).
    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 64) begin
            step(0, 1, 0, 0);
            guard++;
        end
        check("run_until_bound", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; half_period = '0;
        model_tick(1, 0, 0, 0);

        // Reset held with enable high
        repeat (3) step(1, 1, 0, 0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tone", 32'(tone_out), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        // Default half-period: long run without a wrap
        repeat (40) step(0, 1, 0, 0);
        check("default_no_wrap_cnt", 32'(count), 32'd39);
        step(0, 0, 0, 0);

        // Half-period 4
        step(0, 0, 1, 4);
        repeat (20) step(0, 1, 0, 0);

        // Load 6 while count is 1: current period finishes first
        run_until(1);
        step(0, 1, 1, 6);
        repeat (20) step(0, 1, 0, 0);

        // Clamp of 0 and 1 to the minimum, applied from IDLE
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        repeat (10) step(0, 1, 0, 0);

        // Load 3 on the wrap cycle
        run_until(m_act - 1);
        step(0, 1, 1, 3);
        repeat (10) step(0, 1, 0, 0);

        // Enable dropped at count 2, re-enable, then reset mid-run
        run_until(2);
        step(0, 0, 0, 0);
        check("stop_busy", 32'(busy), 32'd0);
        repeat (8) step(0, 1, 0, 0);
        step(0, 1, 1, 7);
        step(1, 1, 0, 0);
        check("midrst_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 0);

        // Random traffic with frequent stops so short periods take effect
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) != 0,
                 $urandom_range(7) == 0, int'($urandom_range(9)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
